// File: rtl/joypad_i2c_target.sv
// joypad_i2c_target: I2C-style target for the joypad link. Answers one 7-bit
// address, serves a snapshot of the button bytes on reads and takes a read
// pointer (first byte) plus data bytes on writes. SDA is open-drain (0 = pull).
module joypad_i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h52,
  parameter int         NUM_BYTES   = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   scl_in,
  input  logic                   sda_in,
  output logic                   sda_out,
  input  logic [8*NUM_BYTES-1:0] tx_data,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  output logic                   rd_done,
  output logic                   busy
);

  localparam int PTR_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [PTR_W-1:0] PTR_MASK = (NUM_BYTES > 1) ? PTR_W'(NUM_BYTES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0]   r_scl_sync, r_sda_sync;
  logic                     r_scl_d, r_sda_d;
  logic                     r_sda;
  logic [3:0]               r_cnt;
  logic [6:0]               r_shift;
  logic [7:0]               r_tx_shift;
  logic [8*NUM_BYTES-1:0]   r_snap;
  logic [PTR_W-1:0]         r_ptr;
  logic                     r_first;
  logic [7:0]               r_rx_data;
  logic                     r_rx_valid, r_rd_done;

  logic       w_scl, w_sda, w_scl_r, w_scl_f, w_start, w_stop;
  logic [7:0] w_rx_byte, w_live_byte, w_snap_byte, w_load_byte;
  logic       w_sda_nxt, w_cnt_clr, w_bit_in, w_rx_done, w_load, w_snap;
  logic       w_tx_step, w_ptr_inc, w_rd_done, w_first_set;

  assign w_scl       = r_scl_sync[SYNC_STAGES-1];
  assign w_sda       = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_r     =  w_scl & ~r_scl_d;
  assign w_scl_f     = ~w_scl &  r_scl_d;
  // Bus conditions need SCL high in both samples so a simultaneous
  // SCL/SDA change is never mistaken for START or STOP.
  assign w_start     = r_scl_d & w_scl &  r_sda_d & ~w_sda;
  assign w_stop      = r_scl_d & w_scl & ~r_sda_d &  w_sda;
  assign w_rx_byte   = {r_shift, w_sda};
  assign w_live_byte = tx_data[{r_ptr, 3'b000} +: 8];
  assign w_snap_byte = r_snap[{r_ptr, 3'b000} +: 8];

  assign sda_out  = r_sda;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rd_done  = r_rd_done;
  assign busy     = (r_state != S_IDLE);

  // Synchronize the bus lines and keep the previous sample for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sync flops reset to the idle-bus level (high) so leaving reset
      // cannot fabricate an edge or a START/STOP.
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let each stage take the old value of
      // the previous one, forming a real shift chain.
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  // State register; SDA drive is registered with it so it moves only after scl_f.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sda   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_sda   <= w_sda_nxt;
    end
  end

  // Next-state, next SDA drive and datapath strobes from bus events.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned and infers a latch.
    w_state_nxt = r_state;
    w_sda_nxt   = r_sda;
    w_load_byte = w_snap_byte;
    w_cnt_clr   = 1'b0;
    w_bit_in    = 1'b0;
    w_rx_done   = 1'b0;
    w_load      = 1'b0;
    w_snap      = 1'b0;
    w_tx_step   = 1'b0;
    w_ptr_inc   = 1'b0;
    w_rd_done   = 1'b0;
    w_first_set = 1'b0;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_sda_nxt   = 1'b1;
    end else if (w_start) begin
      w_state_nxt = S_ADDR;
      w_sda_nxt   = 1'b1;
      w_cnt_clr   = 1'b1;
    end else begin
      unique case (r_state)
        S_ADDR: begin
          if (w_scl_r && r_cnt != 4'd8) begin
            w_bit_in = 1'b1;
            // r_shift holds the seven address bits when the R/W bit arrives
            if (r_cnt == 4'd7 && r_shift != TARGET_ADDR) w_state_nxt = S_WAIT_STOP;
          end else if (w_scl_f && r_cnt == 4'd8) begin
            w_sda_nxt   = 1'b0;
            w_state_nxt = S_ADDR_ACK;
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_f) begin
            if (r_shift[0]) begin
              w_snap      = 1'b1;
              w_load      = 1'b1;
              w_load_byte = w_live_byte;
              w_sda_nxt   = w_live_byte[7];
              w_state_nxt = S_TX;
            end else begin
              w_sda_nxt   = 1'b1;
              w_cnt_clr   = 1'b1;
              w_first_set = 1'b1;
              w_state_nxt = S_RX;
            end
          end
        end
        S_RX: begin
          if (w_scl_r && r_cnt != 4'd8) begin
            w_bit_in  = 1'b1;
            w_rx_done = (r_cnt == 4'd7);
          end else if (w_scl_f && r_cnt == 4'd8) begin
            w_sda_nxt   = 1'b0;
            w_state_nxt = S_RX_ACK;
          end
        end
        S_RX_ACK: begin
          if (w_scl_f) begin
            w_sda_nxt   = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_RX;
          end
        end
        S_TX: begin
          if (w_scl_f) begin
            if (r_cnt == 4'd8) begin
              w_sda_nxt   = 1'b1;
              w_state_nxt = S_TX_ACK;
            end else begin
              w_sda_nxt = r_tx_shift[7];
              w_tx_step = 1'b1;
            end
          end
        end
        S_TX_ACK: begin
          if (w_scl_r) begin
            w_rd_done = 1'b1;
            if (w_sda) w_state_nxt = S_WAIT_STOP;
            else       w_ptr_inc   = 1'b1;
          end else if (w_scl_f) begin
            w_load      = 1'b1;
            w_sda_nxt   = w_snap_byte[7];
            w_state_nxt = S_TX;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: bit counter, shifters, snapshot, read pointer and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_tx_shift <= '0;
      r_snap     <= '0;
      r_ptr      <= '0;
      r_first    <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rd_done  <= 1'b0;
    end else begin
      r_rx_valid <= w_rx_done;
      r_rd_done  <= w_rd_done;
      if (w_cnt_clr)                  r_cnt <= '0;
      else if (w_load)                r_cnt <= 4'd1;
      else if (w_bit_in || w_tx_step) r_cnt <= r_cnt + 4'd1;
      if (w_bit_in) r_shift <= {r_shift[5:0], w_sda};
      if (w_snap)   r_snap  <= tx_data;
      if (w_load)         r_tx_shift <= {w_load_byte[6:0], 1'b0};
      else if (w_tx_step) r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      if (w_rx_done) begin
        r_rx_data <= w_rx_byte;
        if (r_first) r_ptr <= w_rx_byte[PTR_W-1:0] & PTR_MASK;
      end else if (w_ptr_inc) begin
        r_ptr <= (r_ptr + PTR_W'(1)) & PTR_MASK;
      end
      if (w_first_set)    r_first <= 1'b1;
      else if (w_rx_done) r_first <= 1'b0;
    end
  end

endmodule

// File: tb/tb_joypad_i2c_target.sv
// Directed bench for joypad_i2c_target: a bit-banged initiator on an
// open-drain bus, with immediate assertions at each comparison point.
module tb_joypad_i2c_target;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [31:0] tx_data = 32'h1122_A53C;
  logic        sda_out, rx_valid, rd_done, busy;
  logic [7:0]  rx_data;
  logic        w_sda_bus;

  int n_checks = 0;
  int n_errors = 0;
  int n_rd = 0, n_rxv = 0, n_low = 0;
  int base_rd, base_rxv, base_low;
  logic [7:0] rx_q[$];
  logic       ack;
  logic [7:0] d;
  logic [2:0] bits;

  assign w_sda_bus = m_sda & sda_out;

  always #5 clk = ~clk;

  joypad_i2c_target #(.TARGET_ADDR(7'h52), .NUM_BYTES(4), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (m_scl),
    .sda_in   (w_sda_bus),
    .sda_out  (sda_out),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rd_done  (rd_done),
    .busy     (busy)
  );

  // Pulse and drive monitors, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rd_done) n_rd++;
    if (rx_valid) begin
      n_rxv++;
      rx_q.push_back(rx_data);
    end
    if (sda_out === 1'b0) n_low++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end, required end within 2 ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q(1);
    m_scl = 1'b1; wait_q(1);
    m_sda = 1'b0; wait_q(1);
    m_scl = 1'b0; wait_q(1);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q(1);
    m_scl = 1'b1; wait_q(1);
    m_sda = 1'b1; wait_q(1);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wait_q(1);
    m_scl = 1'b1; wait_q(2);
    m_scl = 1'b0; wait_q(1);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_q(1);
    m_scl = 1'b1; wait_q(1);
    b = w_sda_bus; wait_q(1);
    m_scl = 1'b0; wait_q(1);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic a);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(a);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic give_ack);
    for (int i = 7; i >= 0; i--) read_bit(v[i]);
    write_bit(!give_ack);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sda_out", sda_out, 1'b1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rd_done", rd_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_q(2);

    // Plain read from ptr 0: 0x3C then 0xA5
    base_rd = n_rd;
    i2c_start();
    check("t1_busy_start", busy, 1'b1);
    write_byte(8'hA5, ack);
    check("t1_addr_ack", ack, 1'b0);
    read_byte(d, 1'b1);
    check("t1_byte0", d, 8'h3C);
    read_byte(d, 1'b0);
    check("t1_byte1", d, 8'hA5);
    i2c_stop();
    check("t1_rd_done_cnt", n_rd - base_rd, 2);
    check("t1_busy_stop", busy, 1'b0);

    // Address mismatch: never drives, stays parked until STOP
    base_rd = n_rd; base_rxv = n_rxv; base_low = n_low;
    i2c_start();
    write_byte(8'h60, ack);
    check("t2_nack", ack, 1'b1);
    check("t2_busy_wait", busy, 1'b1);
    write_byte(8'hA5, ack);
    check("t2_ignored_addr", ack, 1'b1);
    check("t2_sda_low_cycles", n_low - base_low, 0);
    i2c_stop();
    check("t2_no_rd_done", n_rd - base_rd, 0);
    check("t2_no_rx_valid", n_rxv - base_rxv, 0);
    check("t2_busy_stop", busy, 1'b0);

    // Write pointer 3 and a data byte, then read with wrap
    rx_q.delete();
    base_rxv = n_rxv;
    i2c_start();
    write_byte(8'hA4, ack);
    check("t3_addr_ack", ack, 1'b0);
    write_byte(8'h03, ack);
    check("t3_ptr_ack", ack, 1'b0);
    write_byte(8'h77, ack);
    check("t3_data_ack", ack, 1'b0);
    i2c_stop();
    check("t3_rx_valid_cnt", n_rxv - base_rxv, 2);
    check("t3_rx0", rx_q[0], 8'h03);
    check("t3_rx1", rx_q[1], 8'h77);
    check("t3_rx_data", rx_data, 8'h77);
    i2c_start();
    write_byte(8'hA5, ack);
    check("t3_rd_addr_ack", ack, 1'b0);
    read_byte(d, 1'b1);
    check("t3_byte3", d, 8'h11);
    read_byte(d, 1'b0);
    check("t3_wrap_byte0", d, 8'h3C);
    i2c_stop();

    // Repeated start: pointer 2 then read
    i2c_start();
    write_byte(8'hA4, ack);
    write_byte(8'h02, ack);
    check("t4_ptr_ack", ack, 1'b0);
    i2c_start();
    write_byte(8'hA5, ack);
    check("t4_rd_addr_ack", ack, 1'b0);
    read_byte(d, 1'b1);
    check("t4_byte2", d, 8'h22);
    read_byte(d, 1'b0);
    check("t4_byte3", d, 8'h11);
    i2c_stop();

    // Snapshot: tx_data change mid-read is invisible until next address
    i2c_start();
    write_byte(8'hA5, ack);
    read_byte(d, 1'b1);
    check("t5_old_byte3", d, 8'h11);
    tx_data = 32'h4433_6655;
    read_byte(d, 1'b0);
    check("t5_old_byte0", d, 8'h3C);
    i2c_stop();
    i2c_start();
    write_byte(8'hA5, ack);
    read_byte(d, 1'b1);
    check("t5_new_byte0", d, 8'h55);
    read_byte(d, 1'b0);
    check("t5_new_byte1", d, 8'h66);
    i2c_stop();

    // Reset mid-byte while pulling SDA low (byte1 = 0x66 = 0110_0110)
    i2c_start();
    write_byte(8'hA5, ack);
    for (int i = 2; i >= 0; i--) read_bit(bits[i]);
    check("t6_first_bits", bits, 3'b011);
    check("t6_sda_low", sda_out, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_sda", sda_out, 1'b1);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_rx_data", rx_data, 8'h00);
    m_scl = 1'b1;
    m_sda = 1'b1;
    wait_q(1);
    rst_n = 1'b1;
    wait_q(1);
    i2c_start();
    write_byte(8'hA5, ack);
    check("t6_addr_ack", ack, 1'b0);
    read_byte(d, 1'b0);
    check("t6_ptr0_byte", d, 8'h55);
    i2c_stop();
    check("t6_busy_stop", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
